minimac2_tx_seq: RTL and testbench
==================================

Name: minimac2_tx_seq

Overview:
- PHY-side transmit sequencer for the Minimac2 dual-port packet buffer.
- On a start command it frames a stored packet for MII. It emits the 7-byte preamble and SFD, then reads the packet bytes from the buffer's byte-wide PHY port and shifts them out as nibbles.
- It then enforces the inter-frame gap and pulses done.
- It owns the buffer's PHY-side address; its write enable is tied low by the integrator.

Parameters:
- ADDR_W, 11, byte address width of the buffer PHY port.
- IFG_BYTES, 12, inter-frame gap length in byte times; must be at least 1.

Ports:
- phy_clk  in  1  MII TX clock; the only clock.
- sys_rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle command; sampled only in IDLE.
- base_adr  in  ADDR_W  byte address of the first packet byte; latched on start.
- length  in  ADDR_W+1  packet length in bytes; latched on start.
- abort  in  1  terminates the frame in progress.
- mem_adr  out  ADDR_W  buffer PHY-port byte address.
- mem_dat  in  8  buffer PHY-port read data; 2-cycle registered read latency.
- phy_tx_en  out  1  MII transmit enable.
- phy_tx_data  out  4  MII nibble.
- busy  out  1  high from the cycle after an accepted start until IFG ends.
- done  out  1  one-cycle pulse when a transaction completes.

Behaviour:
- Reset values: phy_tx_en=0, phy_tx_data=0, mem_adr=0, busy=0, done=0; state IDLE. Reset mid-frame drops tx_en immediately and gives no done pulse.
- All outputs are registered.
- Nibble order: low nibble first, then high nibble.
- A byte slot is 2 cycles.
- Memory timing: mem_dat is valid in cycle t+2 for a mem_adr presented in cycle t.
- States: IDLE -> PRE -> SFD -> DATA -> [FCS] -> IFG -> IDLE.
- IDLE: start=1 latches base_adr and length. Length 0 -> no transmission; done pulses in cycle 1; stay IDLE.
- Length greater than 2^ADDR_W is clamped to 2^ADDR_W.
- PRE: cycles 1..14 after start. tx_en=1, data=0x5.
- SFD: cycles 15 (0x5) and 16 (0xD).
- DATA, per byte i:
  - mem_adr = (base+i) mod 2^ADDR_W, driven from the second cycle of slot i-2. For i=0 that is cycle 14; for i=1 it is cycle 16.
  - mem_dat is captured in the second cycle of slot i-1.
  - The low nibble appears in the first cycle of slot i, the high nibble in the second.
  - Byte 0 nibbles appear in cycles 17 and 18.
  - Address wraps modulo 2^ADDR_W.
- After the last data byte, the next state is FCS (feature on) or IFG.
- IFG: 2*IFG_BYTES cycles with tx_en=0 and data=0; busy stays 1.
- Completion: done=1 and busy=0 in the cycle after the last IFG cycle; the state returns to IDLE.
- The earliest next accepted start is in that same done cycle.
- start while busy: ignored, no effect.
- abort=1 in PRE, SFD, DATA or FCS: tx_en=0 from the next cycle, then a full IFG, then done. abort in IDLE or IFG: ignored.
- If start and abort are both high in IDLE, start wins.
- mem_adr holds its last value outside DATA prefetch.
- Total tx_en cycles = 16 + 2*length, plus 8 with FCS.

Optional Feature:
- Macro: MINIMAC2_TX_CRC_EN.
- Defined:
  - Ethernet CRC-32 is computed over the data bytes only: polynomial 0x04C11DB7 reflected, init 0xFFFFFFFF, final complement.
  - The result is appended in the FCS state as 4 bytes, least-significant byte first, each byte low nibble first, immediately after the last data byte.
  - The CRC register reinitialises on every accepted start.
  - abort drops the FCS.
- Undefined: no CRC logic; the frame ends after the last data byte.

Test Plan:
- Reset then idle: all outputs 0; mem_adr=0 throughout.
- base=0x010, length=3, memory 0x010..0x012 = A1 B2 C3, CRC off:
  - start at cycle 0 -> tx_en cycles 1..22.
  - Nibbles: 5 x14, then 5, D, 1, A, 2, B, 3, C.
  - mem_adr = 0x010 at cycle 14.
  - done at cycle 23+2*IFG_BYTES = cycle 47.
- base=0x7FF, length=2 -> mem_adr sequence 0x7FF then 0x000 (wrap). length=0 -> no tx_en; done at cycle 1.
- abort asserted at cycle 18 of a 64-byte frame -> tx_en=0 from cycle 19; done 24 cycles later; start during busy ignored (no second frame).
- MINIMAC2_TX_CRC_EN, length=1, byte 0x00 -> after data nibbles 0,0 comes the FCS D202EF8D, sent as nibbles D, 8, F, E, 2, 0, 2, D; tx_en for 26 cycles.
- Back-to-back: second start in the done cycle -> accepted; its preamble starts the next cycle; frames are separated by exactly 2*IFG_BYTES+1 tx_en-low cycles.

Source files
------------

// File: rtl/minimac2_tx_seq.sv
// rtl/minimac2_tx_seq.sv - MII transmit sequencer for the Minimac2 packet buffer PHY port.
// Optional Ethernet FCS generation when MINIMAC2_TX_CRC_EN is defined.
module minimac2_tx_seq #(
  parameter int ADDR_W    = 11,
  parameter int IFG_BYTES = 12
) (
  input  logic              phy_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic [7:0]        mem_dat,
  output logic              phy_tx_en,
  output logic [3:0]        phy_tx_data,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] SFD  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] IFG  = 3'd5;
`ifdef MINIMAC2_TX_CRC_EN
  localparam logic [2:0] FCS  = 3'd4;
`endif

  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [15:0]     IFG_LAST = 16'(2 * IFG_BYTES - 1);

  logic [2:0]        state;
  logic [4:0]        cnt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   rd_idx;
  logic [ADDR_W:0]   tx_idx;
  logic              hi;
  logic [3:0]        hi_nib;
  logic [15:0]       ifg_cnt;
  logic              in_frame;
`ifdef MINIMAC2_TX_CRC_EN
  logic [31:0]       crc;
  logic [31:0]       fcs_sr;
  logic [2:0]        fcs_cnt;

  // Reflected CRC-32 (poly 0x04C11DB7), one byte LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      r = (r[0] ^ d[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

`ifdef MINIMAC2_TX_CRC_EN
  assign in_frame = (state == PRE) || (state == SFD) || (state == DATA) || (state == FCS);
`else
  assign in_frame = (state == PRE) || (state == SFD) || (state == DATA);
`endif

  always_ff @(posedge phy_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      base_q      <= '0;
      len_q       <= '0;
      rd_idx      <= '0;
      tx_idx      <= '0;
      hi          <= 1'b0;
      hi_nib      <= '0;
      ifg_cnt     <= '0;
      mem_adr     <= '0;
      phy_tx_en   <= 1'b0;
      phy_tx_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef MINIMAC2_TX_CRC_EN
      crc         <= '1;
      fcs_sr      <= '0;
      fcs_cnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && in_frame) begin
        state       <= IFG;
        phy_tx_en   <= 1'b0;
        phy_tx_data <= '0;
        ifg_cnt     <= IFG_LAST;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              base_q <= base_adr;
              len_q  <= length[ADDR_W] ? LEN_MAX : length;
`ifdef MINIMAC2_TX_CRC_EN
              crc    <= '1;
`endif
              if (length == '0) begin
                done <= 1'b1;
              end else begin
                state       <= PRE;
                busy        <= 1'b1;
                phy_tx_en   <= 1'b1;
                phy_tx_data <= 4'h5;
                cnt         <= 5'd1;
              end
            end
          end
          PRE: begin
            cnt <= cnt + 5'd1;
            // First byte is fetched early to cover the 2-cycle read latency.
            if (cnt == 5'd13) begin
              mem_adr <= base_q;
              rd_idx  <= ONE;
            end
            if (cnt == 5'd14) state <= SFD;
          end
          SFD: begin
            if (cnt == 5'd15) begin
              cnt         <= 5'd16;
              phy_tx_data <= 4'hD;
              if (rd_idx < len_q) begin
                mem_adr <= base_q + rd_idx[ADDR_W-1:0];
                rd_idx  <= rd_idx + ONE;
              end
            end else begin
              state       <= DATA;
              phy_tx_data <= mem_dat[3:0];
              hi_nib      <= mem_dat[7:4];
              tx_idx      <= '0;
              hi          <= 1'b0;
`ifdef MINIMAC2_TX_CRC_EN
              crc         <= crc_byte(crc, mem_dat);
`endif
            end
          end
          DATA: begin
            if (!hi) begin
              phy_tx_data <= hi_nib;
              hi          <= 1'b1;
              if (rd_idx < len_q) begin
                mem_adr <= base_q + rd_idx[ADDR_W-1:0];
                rd_idx  <= rd_idx + ONE;
              end
            end else if ((tx_idx + ONE) < len_q) begin
              phy_tx_data <= mem_dat[3:0];
              hi_nib      <= mem_dat[7:4];
              tx_idx      <= tx_idx + ONE;
              hi          <= 1'b0;
`ifdef MINIMAC2_TX_CRC_EN
              crc         <= crc_byte(crc, mem_dat);
`endif
            end else begin
`ifdef MINIMAC2_TX_CRC_EN
              state       <= FCS;
              phy_tx_data <= ~crc[3:0];
              fcs_sr      <= (~crc) >> 4;
              fcs_cnt     <= 3'd7;
`else
              state       <= IFG;
              phy_tx_en   <= 1'b0;
              phy_tx_data <= '0;
              ifg_cnt     <= IFG_LAST;
`endif
            end
          end
`ifdef MINIMAC2_TX_CRC_EN
          FCS: begin
            if (fcs_cnt == 3'd0) begin
              state       <= IFG;
              phy_tx_en   <= 1'b0;
              phy_tx_data <= '0;
              ifg_cnt     <= IFG_LAST;
            end else begin
              phy_tx_data <= fcs_sr[3:0];
              fcs_sr      <= fcs_sr >> 4;
              fcs_cnt     <= fcs_cnt - 3'd1;
            end
          end
`endif
          IFG: begin
            if (ifg_cnt == 16'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              ifg_cnt <= ifg_cnt - 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_minimac2_tx_seq.sv
// tb/tb_minimac2_tx_seq.sv - directed bench for minimac2_tx_seq with a frame-level expectation model.
module tb_minimac2_tx_seq;

  localparam int AW  = 11;
  localparam int IFG = 12;
  localparam int N   = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_adr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] mem_adr;
  logic [7:0]    mem_dat = '0;
  logic          phy_tx_en;
  logic [3:0]    phy_tx_data;
  logic          busy;
  logic          done;

  minimac2_tx_seq #(.ADDR_W(AW), .IFG_BYTES(IFG)) dut (
    .phy_clk(clk), .sys_rst(rst), .start(start), .base_adr(base_adr),
    .length(length), .abort(abort), .mem_adr(mem_adr), .mem_dat(mem_dat),
    .phy_tx_en(phy_tx_en), .phy_tx_data(phy_tx_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  logic [7:0] r1 = '0;
  always @(posedge clk) begin
    r1      <= mem[mem_adr];
    mem_dat <= r1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_en[N], exp_dat[N], exp_busy[N], exp_done[N], exp_adr[N];
  int act_en[N], act_dat[N], act_done[N], act_adr[N];
  int cyc_pass = 0, cyc_tot = 0, lit_pass = 0, lit_tot = 0;
  bit chk_on = 1'b0;
  logic [31:0] crc_tab [0:255];

  task automatic chk_cyc(input string name, input int act, input int exp);
    cyc_tot++;
    if (act == exp) cyc_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic chk_lit(input string name, input int act, input int exp);
    lit_tot++;
    if (act == exp) lit_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      act_en[cyc]   = int'(phy_tx_en);
      act_dat[cyc]  = int'(phy_tx_data);
      act_done[cyc] = int'(done);
      act_adr[cyc]  = int'(mem_adr);
      chk_cyc("tx_en",   int'(phy_tx_en),   exp_en[cyc]);
      chk_cyc("tx_data", int'(phy_tx_data), exp_dat[cyc]);
      chk_cyc("busy",    int'(busy),        exp_busy[cyc]);
      chk_cyc("done",    int'(done),        exp_done[cyc]);
      chk_cyc("mem_adr", int'(mem_adr),     exp_adr[cyc]);
    end
  end

  function automatic logic [31:0] crc32(input int base, input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++)
      c = crc_tab[(c[7:0] ^ mem[(base + i) % 2048])] ^ (c >> 8);
    return ~c;
  endfunction

  // Expected outputs of one frame started in cycle s; ab is the abort cycle relative to s, or -1.
  task automatic model_frame(input int s, input int base, input int len, input int ab);
    int l, n, last, nf, f;
    int nib[$];
    logic [31:0] fcs;
    l = (len > 2048) ? 2048 : len;
    if (l == 0) begin
      exp_done[s+1] = 1;
      return;
    end
    for (int k = 0; k < 15; k++) nib.push_back(5);
    nib.push_back(13);
    for (int i = 0; i < l; i++) begin
      nib.push_back(int'(mem[(base + i) % 2048]) % 16);
      nib.push_back(int'(mem[(base + i) % 2048]) / 16);
    end
`ifdef MINIMAC2_TX_CRC_EN
    fcs = crc32(base, l);
    for (int k = 0; k < 8; k++) nib.push_back(int'((fcs >> (4 * k)) & 32'hF));
`else
    fcs = 32'h0;
`endif
    n = nib.size();
    last = (ab >= 1 && ab <= n) ? ab : n;
    for (int k = 1; k <= last; k++) begin
      exp_en[s+k] = 1; exp_dat[s+k] = nib[k-1]; exp_busy[s+k] = 1;
    end
    for (int k = last + 1; k <= last + 2 * IFG; k++) exp_busy[s+k] = 1;
    exp_done[s+last+2*IFG+1] = 1;
    nf = 0;
    for (int i = 0; i < l; i++) if (14 + 2 * i <= last) nf++;
    for (int i = 0; i < nf; i++) begin
      f = s + 14 + 2 * i;
      for (int c = f; c < ((i == nf - 1) ? N : f + 2); c++) exp_adr[c] = (base + i) % 2048;
    end
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < N; c++) begin
      exp_en[c] = 0; exp_dat[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_adr[c] = 0;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_frame(input int base, input int len);
    base_adr = AW'(base);
    length   = (AW+1)'(len);
    start    = 1'b1;
    model_frame(cyc, base, len, -1);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  function automatic int count_en(input int a, input int b);
    int k;
    k = 0;
    for (int c = a; c <= b; c++) k += act_en[c];
    return k;
  endfunction

  initial begin
    logic [31:0] t;
    for (int i = 0; i < 2048; i++) mem[i] = 8'((i * 7 + 3) ^ (i >> 3));
    mem[16] = 8'hA1; mem[17] = 8'hB2; mem[18] = 8'hC3;
    mem[2047] = 8'h5E; mem[0] = 8'h3C; mem[64] = 8'h00;
    for (int n = 0; n < 256; n++) begin
      t = 32'(n);
      for (int k = 0; k < 8; k++) t = t[0] ? (32'hEDB88320 ^ (t >> 1)) : (t >> 1);
      crc_tab[n] = t;
    end
    clear_from(0);

    repeat (3) @(posedge clk);
    #1;
    chk_lit("reset tx_en",   int'(phy_tx_en),   0);
    chk_lit("reset tx_data", int'(phy_tx_data), 0);
    chk_lit("reset mem_adr", int'(mem_adr),     0);
    chk_lit("reset busy",    int'(busy),        0);
    chk_lit("reset done",    int'(done),        0);
    rst = 1'b0;
    chk_on = 1'b1;

    wait_cyc(10);  start_frame(12'h010, 3);
    wait_cyc(70);  start_frame(12'h7FF, 2);
    wait_cyc(120); start_frame(12'h123, 0);

    wait_cyc(130);
    base_adr = 11'h100; length = 12'd64; start = 1'b1;
    model_frame(cyc, 12'h100, 64, 18);
    @(posedge clk); #1; start = 1'b0;
    wait_cyc(140); base_adr = 11'h300; length = 12'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_cyc(148); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    wait_cyc(160); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;

    wait_cyc(180); start_frame(12'h020, 2);
    wait_cyc(225); abort = 1'b1; start_frame(12'h030, 1); abort = 1'b0;

    wait_cyc(280); start_frame(12'h040, 1);
    wait_cyc(340); start_frame(12'h200, 12'hFFF);

    wait_cyc(4500); start_frame(12'h010, 5);
    wait_cyc(4520); rst = 1'b1; clear_from(cyc);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    wait_cyc(4545);

    chk_lit("f1 tx_en cycles", count_en(10, 60), 22);
    chk_lit("f1 first tx_en", act_en[11], 1);
    chk_lit("f1 nib 17", act_dat[27], 1);
    chk_lit("f1 nib 18", act_dat[28], 10);
    chk_lit("f1 nib 21", act_dat[31], 3);
    chk_lit("f1 nib 22", act_dat[32], 12);
    chk_lit("f1 sfd", act_dat[26], 13);
    chk_lit("f1 adr c14", act_adr[24], 16);
    chk_lit("f1 done c47", act_done[57], 1);
    chk_lit("wrap adr c14", act_adr[84], 12'h7FF);
    chk_lit("wrap adr c16", act_adr[86], 0);
    chk_lit("wrap nib c19", act_dat[89], 12);
    chk_lit("len0 done c1", act_done[121], 1);
    chk_lit("len0 tx_en", count_en(120, 129), 0);
    chk_lit("abort tx_en c18", act_en[148], 1);
    chk_lit("abort tx_en c19", act_en[149], 0);
    chk_lit("abort done", act_done[173], 1);
    chk_lit("abort no 2nd frame", count_en(149, 179), 0);
    chk_lit("b2b gap", 25 - count_en(201, 225), 25);
    chk_lit("b2b 2nd preamble", act_en[226], 1);
`ifdef MINIMAC2_TX_CRC_EN
    chk_lit("crc tx_en cycles", count_en(280, 330), 26);
    chk_lit("crc fcs nibbles", (act_dat[299] << 28) | (act_dat[300] << 24) | (act_dat[301] << 20)
            | (act_dat[302] << 16) | (act_dat[303] << 12) | (act_dat[304] << 8)
            | (act_dat[305] << 4) | act_dat[306], 32'hD8FE202D);
    chk_lit("clamp tx_en cycles", count_en(340, 4499), 4120);
`else
    chk_lit("nocrc tx_en cycles", count_en(280, 330), 18);
    chk_lit("clamp tx_en cycles", count_en(340, 4499), 4112);
`endif
    chk_lit("clamp last adr", act_adr[340 + 14 + 2 * 2047], (12'h200 + 2047) % 2048);
    chk_lit("reset drops tx_en", act_en[4520], 0);
    chk_lit("reset no done", count_en(4521, 4544) + act_done[4533], 0);

    $display("%0d/%0d checks passed", cyc_pass + lit_pass, cyc_tot + lit_tot);
    $finish;
  end

endmodule
